// File: rtl/projectile_ctrl.sv
// Projectile controller: launches a square sprite from a spawn point and moves
// it horizontally one step per frame until it hits a target or leaves the screen.
// A short cooldown then follows before the next launch is accepted.
module projectile_ctrl #(
  parameter int SPEED           = 4,
  parameter int SIZE            = 8,
  parameter int X_MAX           = 639,
  parameter int COOLDOWN_FRAMES = 15
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [9:0] Spawn_X,
  input  logic [9:0] Spawn_Y,
  input  logic       dir,
  input  logic       contact,
  output logic [9:0] Proj_X,
  output logic [9:0] Proj_Y,
  output logic       active,
  output logic       hit,
  output logic       ready
);

  typedef enum logic [1:0] {
    IDLE,
    FLYING,
    COOLDOWN
  } state_t;

  // The cooldown counter only has to reach COOLDOWN_FRAMES-1 before the exit edge.
  localparam int CNT_W = (COOLDOWN_FRAMES > 2) ? $clog2(COOLDOWN_FRAMES) : 1;
  localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(COOLDOWN_FRAMES - 1);

  // Boundary math is done in 11 bits so neither edge test can wrap.
  localparam logic [10:0] STEP  = 11'(SPEED);
  localparam logic [10:0] REACH = 11'(SPEED + SIZE);
  localparam logic [10:0] LIMIT = 11'(X_MAX + 1);

  state_t           state;
  logic             frame_prev;
  logic             dir_latched;
  logic [CNT_W-1:0] cd_count;

  logic             frame_edge;
  logic [10:0]      x_ext;
  logic             right_out;
  logic             left_out;

  assign frame_edge = frame_clk & ~frame_prev;
  assign x_ext      = {1'b0, Proj_X};
  assign right_out  = (x_ext + REACH) > LIMIT;
  assign left_out   = x_ext < STEP;

  assign ready  = (state == IDLE);
  assign active = (state == FLYING);

  // Launch, per-frame motion, hit/despawn handling and cooldown timing.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      frame_prev  <= 1'b0;
      dir_latched <= 1'b0;
      cd_count    <= '0;
      Proj_X      <= '0;
      Proj_Y      <= '0;
      hit         <= 1'b0;
    end else begin
      frame_prev <= frame_clk;
      hit        <= 1'b0;
      case (state)
        IDLE: begin
          if (fire) begin
            Proj_X      <= Spawn_X;
            Proj_Y      <= Spawn_Y;
            dir_latched <= dir;
            state       <= FLYING;
          end
        end
        FLYING: begin
          if (contact) begin
            hit      <= 1'b1;
            cd_count <= '0;
            state    <= COOLDOWN;
          end else if (frame_edge) begin
            if (dir_latched) begin
              if (right_out) begin
                cd_count <= '0;
                state    <= COOLDOWN;
              end else begin
                Proj_X <= Proj_X + STEP[9:0];
              end
            end else begin
              if (left_out) begin
                cd_count <= '0;
                state    <= COOLDOWN;
              end else begin
                Proj_X <= Proj_X - STEP[9:0];
              end
            end
          end
        end
        COOLDOWN: begin
          if (frame_edge) begin
            if (cd_count == CD_LAST) begin
              state <= IDLE;
            end else begin
              cd_count <= cd_count + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_projectile_ctrl.sv
// Directed self-checking bench for projectile_ctrl with hand-computed expectations.
module tb_projectile_ctrl;

  logic       Clk;
  logic       Reset_n;
  logic       frame_clk;
  logic       fire;
  logic [9:0] Spawn_X;
  logic [9:0] Spawn_Y;
  logic       dir;
  logic       contact;
  logic [9:0] Proj_X;
  logic [9:0] Proj_Y;
  logic       active;
  logic       hit;
  logic       ready;

  int checks_done = 0;
  int checks_failed = 0;
  int hit_cycles = 0;
  int hit_mark;

  projectile_ctrl #(
    .SPEED(4),
    .SIZE(8),
    .X_MAX(639),
    .COOLDOWN_FRAMES(15)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .frame_clk(frame_clk),
    .fire(fire),
    .Spawn_X(Spawn_X),
    .Spawn_Y(Spawn_Y),
    .dir(dir),
    .contact(contact),
    .Proj_X(Proj_X),
    .Proj_Y(Proj_Y),
    .active(active),
    .hit(hit),
    .ready(ready)
  );

  // Free-running system clock.
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Count every cycle in which hit is high, sampled away from the active edge.
  always @(negedge Clk) begin
    if (hit) hit_cycles = hit_cycles + 1;
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks_done = checks_done + 1;
    if (actual !== expected) begin
      checks_failed = checks_failed + 1;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic stepClock();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [9:0] sx, input logic [9:0] sy,
                               input logic d, input logic f);
    Spawn_X = sx;
    Spawn_Y = sy;
    dir     = d;
    fire    = f;
  endtask

  // One frame_clk high cycle followed by one low cycle: exactly one frame edge.
  task automatic pulseFrames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1;
      stepClock();
      frame_clk = 1'b0;
      stepClock();
    end
  endtask

  initial begin
    Reset_n   = 1'b0;
    frame_clk = 1'b0;
    contact   = 1'b0;
    applyStimulus(10'd0, 10'd0, 1'b0, 1'b0);

    // Reset state
    #12;
    checkOutput("rst_ready", int'(ready), 1);
    checkOutput("rst_active", int'(active), 0);
    checkOutput("rst_hit", int'(hit), 0);
    checkOutput("rst_x", int'(Proj_X), 0);
    checkOutput("rst_y", int'(Proj_Y), 0);
    Reset_n = 1'b1;

    // Launch right from (100,200); dir/spawn changes in flight are ignored
    applyStimulus(10'd100, 10'd200, 1'b1, 1'b1);
    stepClock();
    applyStimulus(10'd5, 10'd5, 1'b0, 1'b0);
    checkOutput("a_active", int'(active), 1);
    checkOutput("a_ready", int'(ready), 0);
    checkOutput("a_x0", int'(Proj_X), 100);
    checkOutput("a_y0", int'(Proj_Y), 200);
    pulseFrames(3);
    checkOutput("a_x3", int'(Proj_X), 112);
    checkOutput("a_y3", int'(Proj_Y), 200);
    hit_mark = hit_cycles;
    contact = 1'b1;
    stepClock();
    contact = 1'b0;
    checkOutput("a_hit", int'(hit), 1);
    checkOutput("a_cool_active", int'(active), 0);
    checkOutput("a_hold_x", int'(Proj_X), 112);
    stepClock();
    checkOutput("a_hit_drop", int'(hit), 0);
    pulseFrames(15);
    checkOutput("a_cool_done", int'(ready), 1);
    checkOutput("a_hit_count", hit_cycles - hit_mark, 1);

    // Right-edge despawn: 620 -> 624 -> 628 -> 632, then 632+12 > 640
    hit_mark = hit_cycles;
    applyStimulus(10'd620, 10'd50, 1'b1, 1'b1);
    stepClock();
    fire = 1'b0;
    pulseFrames(3);
    checkOutput("b_x632", int'(Proj_X), 632);
    checkOutput("b_active", int'(active), 1);
    pulseFrames(1);
    checkOutput("b_despawn", int'(active), 0);
    checkOutput("b_hold_x", int'(Proj_X), 632);
    pulseFrames(14);
    checkOutput("b_ready14", int'(ready), 0);
    pulseFrames(1);
    checkOutput("b_ready15", int'(ready), 1);
    checkOutput("b_no_hit", hit_cycles - hit_mark, 0);

    // Left-edge despawn: 6 -> 2, then 2 < 4
    hit_mark = hit_cycles;
    applyStimulus(10'd6, 10'd30, 1'b0, 1'b1);
    stepClock();
    fire = 1'b0;
    pulseFrames(1);
    checkOutput("c_x2", int'(Proj_X), 2);
    pulseFrames(1);
    checkOutput("c_despawn", int'(active), 0);
    checkOutput("c_hold_x", int'(Proj_X), 2);
    pulseFrames(15);
    checkOutput("c_ready", int'(ready), 1);
    checkOutput("c_no_hit", hit_cycles - hit_mark, 0);

    // Contact coincident with a frame edge wins; held contact gives one hit only
    applyStimulus(10'd300, 10'd100, 1'b1, 1'b1);
    stepClock();
    fire = 1'b0;
    pulseFrames(1);
    checkOutput("d_x304", int'(Proj_X), 304);
    hit_mark = hit_cycles;
    contact   = 1'b1;
    frame_clk = 1'b1;
    stepClock();
    frame_clk = 1'b0;
    checkOutput("d_hit", int'(hit), 1);
    checkOutput("d_hold_x", int'(Proj_X), 304);
    checkOutput("d_active", int'(active), 0);
    checkOutput("d_ready", int'(ready), 0);
    stepClock();
    checkOutput("d_hit_drop", int'(hit), 0);
    pulseFrames(15);
    stepClock();
    checkOutput("d_idle", int'(ready), 1);
    checkOutput("d_hit_count", hit_cycles - hit_mark, 1);
    contact = 1'b0;

    // Asynchronous reset mid-flight, then fire accepted on first edge after release
    applyStimulus(10'd50, 10'd60, 1'b1, 1'b1);
    stepClock();
    fire = 1'b0;
    pulseFrames(1);
    checkOutput("e_x54", int'(Proj_X), 54);
    hit_mark = hit_cycles;
    Reset_n = 1'b0;
    #2;
    checkOutput("e_rst_x", int'(Proj_X), 0);
    checkOutput("e_rst_y", int'(Proj_Y), 0);
    checkOutput("e_rst_active", int'(active), 0);
    checkOutput("e_rst_ready", int'(ready), 1);
    applyStimulus(10'd70, 10'd80, 1'b0, 1'b1);
    #1;
    Reset_n = 1'b1;
    stepClock();
    fire = 1'b0;
    checkOutput("e_refire", int'(active), 1);
    checkOutput("e_refire_x", int'(Proj_X), 70);
    checkOutput("e_no_hit", hit_cycles - hit_mark, 0);
    Reset_n = 1'b0;
    #2;
    Reset_n = 1'b1;

    // Fire held throughout: hit, cooldown, relaunch with current spawn values
    applyStimulus(10'd400, 10'd300, 1'b1, 1'b1);
    stepClock();
    checkOutput("f_launch_x", int'(Proj_X), 400);
    contact = 1'b1;
    stepClock();
    contact = 1'b0;
    checkOutput("f_hit", int'(hit), 1);
    applyStimulus(10'd10, 10'd20, 1'b0, 1'b1);
    pulseFrames(14);
    checkOutput("f_cool_ready", int'(ready), 0);
    checkOutput("f_cool_x", int'(Proj_X), 400);
    frame_clk = 1'b1;
    stepClock();
    frame_clk = 1'b0;
    checkOutput("f_idle", int'(ready), 1);
    stepClock();
    checkOutput("f_relaunch", int'(active), 1);
    checkOutput("f_relaunch_x", int'(Proj_X), 10);
    checkOutput("f_relaunch_y", int'(Proj_Y), 20);
    fire = 1'b0;
    pulseFrames(1);
    checkOutput("f_left_x", int'(Proj_X), 6);

    $display("End of test - %0d assertions evaluated, %0d failures", checks_done, checks_failed);
    $finish;
  end

endmodule
